fifo_level: RTL

Parametrised synchronous FIFO with occupancy reporting, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Successor to the basic FIFO, with the same read/write interface and the same read-data timing.
- Used as the buffering stage between producer/consumer blocks (UART, SPI, stream sources) that need early back-pressure and error visibility.

---
 rtl/fifo_level.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_level.sv
// fifo_level: synchronous show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow error flags.
module fifo_level #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_clear,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Width-matched constants so every compare/add is the same width as the count.
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_TH   = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0]   AE_TH   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic full, empty, wr_ok, rd_ok;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Full FIFO still accepts a write when a read frees the head in the same
    // edge; flush suppresses both so nothing lands in memory that cycle.
    assign wr_ok = i_wr & (~full | i_rd) & ~i_clear;
    assign rd_ok = i_rd & ~empty & ~i_clear;

    // Next-state for pointers, count and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A read on empty flags underflow even if a write lands the same edge.
            ovf_d = ovf_q | (i_wr & full & ~i_rd);
            udf_d = udf_q | (i_rd & empty);
        end
    end

    // Control state: asynchronous reset, otherwise load next-state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array is not reset; an empty FIFO's head is don't-care.
    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_w_data;
    end

    assign o_r_data       = mem_q[rd_ptr_q];
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (count_q >= AF_TH);
    assign o_almost_empty = (count_q <= AE_TH);
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule
